// File: rtl/misr_ctrl_pkg.sv
// Shared types for the MISR session controller: FSM state encoding and id-width helper.
package misr_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPACT   = 3'd1,
    WAIT_DONE = 3'd2,
    CHECK     = 3'd3,
    REARM     = 3'd4
  } state_e;

  // Requester index width; never below 1 so a single-bit id still has a port.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/misr_session_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr wins.
// The pointer register lives in the parent.
module rr_arbiter
  import misr_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  int j;

  // Scan from farthest to nearest so the last hit is the closest to ptr.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/misr_session_ctrl.sv
// Round-robin session scheduler for one shared MISR: stream N words, check signature, re-arm.
// Optional WAIT_DONE timeout with to_err_o when MISR_CTRL_TIMEOUT_EN is defined.
module misr_session_ctrl
  import misr_ctrl_pkg::*;
#(
  parameter int N      = 64,
  parameter int NREQ   = 4,
  parameter int TO_CYC = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*N-1:0]       data_i,
  input  logic [NREQ*N-1:0]       golden_i,
  input  logic [N-1:0]            poly_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic                    resp_valid_o,
  output logic [id_w(NREQ)-1:0]   resp_id_o,
  output logic                    resp_pass_o,
  output logic [N-1:0]            resp_sig_o,
`ifdef MISR_CTRL_TIMEOUT_EN
  output logic                    to_err_o,
`endif
  output logic                    busy_o,
  output logic                    misr_en_o,
  output logic                    misr_done_in_o,
  output logic [N-1:0]            misr_data_o,
  output logic [N-1:0]            misr_coeff_o,
  input  logic [N-1:0]            misr_sig_i,
  input  logic                    misr_done_i
);

  localparam int IDW = id_w(NREQ);
  localparam int CW  = $clog2(N) + 1;

  if (NREQ < 2 || N < 2 || TO_CYC < 1) begin : g_cfg_err
    $error("misr_session_ctrl: need NREQ>=2, N>=2, TO_CYC>=1");
  end

  state_e          state, state_d;
  logic [IDW-1:0]  ptr, win;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    sig_q;
  logic            pass_q;
  logic [IDW-1:0]  id_q;

  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;
  logic [N-1:0]    gold_sel;
  logic            pass_now;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req (req_i),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign arb_any  = |arb_gnt;
  assign gold_sel = golden_i[int'(win)*N +: N];

`ifdef MISR_CTRL_TIMEOUT_EN
  localparam int TCW = $clog2(TO_CYC + 1);
  logic [TCW-1:0] to_cnt;
  logic           to_flag;

  // to_flag tracks the last WAIT_DONE cycle: set only if it left on timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (state == WAIT_DONE) begin
      to_cnt  <= to_cnt + TCW'(1);
      to_flag <= !misr_done_i;
    end else begin
      to_cnt  <= '0;
    end
  end

  assign pass_now = (misr_sig_i == gold_sel) && !to_flag;
  assign to_err_o = (state == CHECK) && to_flag;
`else
  assign pass_now = (misr_sig_i == gold_sel);
`endif

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:      if (arb_any) state_d = COMPACT;
      COMPACT:   if (cnt == CW'(N - 1)) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (misr_done_i) state_d = CHECK;
`ifdef MISR_CTRL_TIMEOUT_EN
        else if (to_cnt == TCW'(TO_CYC - 1)) state_d = CHECK;
`endif
      end
      CHECK:     state_d = REARM;
      REARM:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_o          = '0;
    misr_data_o    = '0;
    misr_en_o      = 1'b0;
    misr_done_in_o = 1'b0;
    if (state == COMPACT) begin
      gnt_o[win]  = 1'b1;
      misr_data_o = data_i[int'(win)*N +: N];
      misr_en_o   = 1'b1;
    end
    if (state == REARM) begin
      misr_en_o      = 1'b1;
      misr_done_in_o = 1'b1;
    end
  end

  // Result is live during CHECK and held from the capture registers afterwards.
  assign resp_valid_o = (state == CHECK);
  assign resp_sig_o   = resp_valid_o ? misr_sig_i : sig_q;
  assign resp_pass_o  = resp_valid_o ? pass_now   : pass_q;
  assign resp_id_o    = resp_valid_o ? win        : id_q;
  assign busy_o       = (state != IDLE);
  assign misr_coeff_o = poly_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      win    <= '0;
      cnt    <= '0;
      sig_q  <= '0;
      pass_q <= 1'b0;
      id_q   <= '0;
    end else begin
      state <= state_d;
      unique case (state)
        IDLE: if (arb_any) begin
          win <= arb_idx;
          ptr <= (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + IDW'(1);
          cnt <= '0;
        end
        COMPACT: cnt <= cnt + CW'(1);
        CHECK: begin
          sig_q  <= misr_sig_i;
          pass_q <= pass_now;
          id_q   <= win;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_misr_session_ctrl.sv
// Self-checking bench for misr_session_ctrl with a behavioural MISR peer and an expected-result queue.
module tb_misr_session_ctrl;

  localparam int N      = 8;
  localparam int NREQ   = 4;
  localparam int TO_CYC = 8;
  localparam int P      = N + 4;
  localparam logic [N-1:0] POLY = 8'h1D;

  logic                clk, rst_n;
  logic [NREQ-1:0]     req_i;
  logic [NREQ*N-1:0]   data_i, golden_i;
  logic [N-1:0]        poly_i;
  logic [NREQ-1:0]     gnt_o;
  logic                resp_valid_o, resp_pass_o, busy_o;
  logic [1:0]          resp_id_o;
  logic [N-1:0]        resp_sig_o;
  logic                misr_en_o, misr_done_in_o;
  logic [N-1:0]        misr_data_o, misr_coeff_o, misr_sig_i;
  logic                misr_done_i;
`ifdef MISR_CTRL_TIMEOUT_EN
  logic                to_err_o;
`endif

  misr_session_ctrl #(.N(N), .NREQ(NREQ), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .data_i(data_i), .golden_i(golden_i),
    .poly_i(poly_i), .gnt_o(gnt_o), .resp_valid_o(resp_valid_o), .resp_id_o(resp_id_o),
    .resp_pass_o(resp_pass_o), .resp_sig_o(resp_sig_o),
`ifdef MISR_CTRL_TIMEOUT_EN
    .to_err_o(to_err_o),
`endif
    .busy_o(busy_o), .misr_en_o(misr_en_o), .misr_done_in_o(misr_done_in_o),
    .misr_data_o(misr_data_o), .misr_coeff_o(misr_coeff_o), .misr_sig_i(misr_sig_i),
    .misr_done_i(misr_done_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    int         acc;
    int         rcyc;
    logic [N-1:0] sig;
    logic       pass;
    logic       to;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0, n_chk = 0, n_pass = 0, run_len = 0;
  logic [N-1:0] model_sig;
  bit           seq_mode, block_done;
  int           seq_base;

  function automatic logic [N-1:0] step(logic [N-1:0] s, logic [N-1:0] d, logic [N-1:0] p);
    return {s[N-2:0], 1'b0} ^ (s[N-1] ? p : '0) ^ d;
  endfunction

  // Word driven on requester r's slice during bench cycle c.
  function automatic logic [N-1:0] word(int r, int c);
    if (seq_mode && r == 0) return N'(c - seq_base);
    return N'(c * 37 + r * 91 + 3);
  endfunction

  // Session accepted in cycle acc compacts the words of cycles acc+1..acc+N.
  function automatic logic [N-1:0] next_sig(int r, int acc, logic [N-1:0] s);
    for (int k = 1; k <= N; k++) s = step(s, word(r, acc + k), POLY);
    return s;
  endfunction

  task automatic push_sess(input int r, input int acc, input int rcyc, input bit to_exp);
    exp_t e;
    model_sig = next_sig(r, acc, model_sig);
    e.id = r; e.acc = acc; e.rcyc = rcyc; e.sig = model_sig; e.to = to_exp;
    e.pass = !to_exp && (model_sig == golden_i[r*N +: N]);
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int r = 0; r < NREQ; r++) data_i[r*N +: N] = word(r, cyc);
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  // Behavioural MISR peer: compacts N enabled words, then holds until re-armed.
  logic [N-1:0] m_sig;
  logic [3:0]   m_cnt;
  logic         m_done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sig <= '0; m_cnt <= '0; m_done <= 1'b0;
    end else if (misr_en_o) begin
      if (misr_done_in_o) begin
        if (m_done) begin m_done <= 1'b0; m_cnt <= '0; end
      end else if (!m_done) begin
        m_sig <= step(m_sig, misr_data_o, misr_coeff_o);
        m_cnt <= m_cnt + 4'd1;
        if (m_cnt == 4'(N - 1)) m_done <= 1'b1;
      end
    end
  end
  assign misr_sig_i  = m_sig;
  assign misr_done_i = m_done && !block_done;

  // Scoreboard: grant windows and responses against queued expectations.
  always @(negedge clk) begin
    logic [NREQ-1:0] eg;
    exp_t e;
    #2;
    if (!rst_n) run_len = 0;
    else begin
      if (gnt_o != '0) begin
        if (run_len == 0) begin
          n_chk++;
          eg = '0;
          if (sb.size() != 0) eg[sb[0].id] = 1'b1;
          if (sb.size() != 0 && gnt_o === eg && cyc == sb[0].acc + 1) n_pass++;
          else $display("FAIL gnt_start cyc=%0d gnt=%b expected gnt=%b at cyc=%0d", cyc, gnt_o, eg,
                        (sb.size() != 0) ? sb[0].acc + 1 : -1);
        end
        run_len++;
      end else if (run_len != 0) begin
        n_chk++;
        if (run_len == N) n_pass++;
        else $display("FAIL gnt_len cyc=%0d got %0d cycles, expected %0d", cyc, run_len, N);
        run_len = 0;
      end
      if (resp_valid_o) begin
        n_chk++;
        if (sb.size() == 0) $display("FAIL resp_unexpected cyc=%0d id=%0d", cyc, resp_id_o);
        else begin
          e = sb.pop_front();
          if (cyc == e.rcyc && resp_id_o === 2'(e.id) && resp_sig_o === e.sig && resp_pass_o === e.pass
`ifdef MISR_CTRL_TIMEOUT_EN
              && to_err_o === e.to
`endif
             ) n_pass++;
          else $display("FAIL resp cyc=%0d id=%0d sig=%h pass=%b ; expected cyc=%0d id=%0d sig=%h pass=%b to=%b",
                        cyc, resp_id_o, resp_sig_o, resp_pass_o, e.rcyc, e.id, e.sig, e.pass, e.to);
        end
      end
    end
  end

  task automatic test_reset();
    tick(); #2;
    n_chk++;
    if ({gnt_o, busy_o, resp_valid_o, misr_en_o, misr_done_in_o, resp_pass_o, resp_id_o} !== '0)
      $display("FAIL reset_ctrl gnt=%b busy=%b vld=%b en=%b din=%b pass=%b id=%0d, expected all 0",
               gnt_o, busy_o, resp_valid_o, misr_en_o, misr_done_in_o, resp_pass_o, resp_id_o);
    else n_pass++;
    n_chk++;
    if (misr_data_o !== '0 || resp_sig_o !== '0)
      $display("FAIL reset_data data=%h sig=%h, expected 0", misr_data_o, resp_sig_o);
    else n_pass++;
    n_chk++;
    if (misr_coeff_o !== POLY) $display("FAIL reset_coeff got %h, expected %h", misr_coeff_o, POLY);
    else n_pass++;
  endtask

  task automatic test_rr_all();
    int a;
    logic [N-1:0] s;
    a = cyc;
    s = model_sig;
    for (int k = 0; k < NREQ; k++) begin
      s = next_sig(k, a + k * P, s);
      golden_i[k*N +: N] = s;
    end
    for (int k = 0; k < 5; k++) push_sess(k % NREQ, a + k * P, a + k * P + N + 2, 1'b0);
    req_i = 4'b1111;
    run_to(a + 2 * P + 1); #2;
    n_chk++;
    if (gnt_o !== 4'b0100) $display("FAIL rr_third gnt=%b, expected 0100", gnt_o);
    else n_pass++;
    run_to(a + 4 * P + 1);
    req_i = 4'b0001;
    run_to(a + 4 * P + N + 2);
    req_i = '0;
    run_to(a + 5 * P); #2;
    n_chk++;
    if (busy_o !== 1'b0) $display("FAIL rr_idle busy=%b, expected 0", busy_o);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int a, b;
    a = cyc;
    push_sess(1, a, a + N + 2, 1'b0);
    req_i = 4'b0010;
    run_to(a + N + 2);
    req_i = '0;
    run_to(a + P);
    b = cyc;
    push_sess(0, b, b + N + 2, 1'b0);
    push_sess(1, b + P, b + P + N + 2, 1'b0);
    req_i = 4'b0011;
    run_to(b + 1); #2;
    n_chk++;
    if (gnt_o !== 4'b0001) $display("FAIL wrap_first gnt=%b, expected 0001", gnt_o);
    else n_pass++;
    run_to(b + N + 2);
    req_i = 4'b0010;
    run_to(b + P + 1); #2;
    n_chk++;
    if (gnt_o !== 4'b0010) $display("FAIL wrap_second gnt=%b, expected 0010", gnt_o);
    else n_pass++;
    run_to(b + P + N + 2);
    req_i = '0;
    run_to(b + 2 * P);
  endtask

  task automatic test_single(input bit flip);
    int a;
    logic [N-1:0] s;
    a = cyc;
    seq_mode = 1'b1;
    seq_base = a;
    s = next_sig(0, a, model_sig);
    golden_i[N-1:0] = s ^ N'(flip);
    push_sess(0, a, a + N + 2, 1'b0);
    req_i = 4'b0001;
    run_to(a + 1); #2;
    n_chk++;
    if (busy_o !== 1'b1 || misr_data_o !== 8'd1)
      $display("FAIL single_start busy=%b data=%h, expected 1 / 01", busy_o, misr_data_o);
    else n_pass++;
    run_to(a + N + 2); #2;
    n_chk++;
    if (resp_valid_o !== 1'b1 || resp_pass_o !== !flip)
      $display("FAIL single_resp vld=%b pass=%b, expected 1 / %b", resp_valid_o, resp_pass_o, !flip);
    else n_pass++;
    req_i = '0;
    run_to(a + N + 3); #2;
    n_chk++;
    if ({misr_en_o, misr_done_in_o} !== 2'b11 || misr_data_o !== '0)
      $display("FAIL rearm en=%b din=%b data=%h, expected 1 1 00", misr_en_o, misr_done_in_o, misr_data_o);
    else n_pass++;
    run_to(a + P); #2;
    n_chk++;
    if (resp_valid_o !== 1'b0 || resp_sig_o !== s || resp_pass_o !== !flip || busy_o !== 1'b0)
      $display("FAIL resp_hold vld=%b sig=%h pass=%b busy=%b, expected 0 %h %b 0",
               resp_valid_o, resp_sig_o, resp_pass_o, busy_o, s, !flip);
    else n_pass++;
    seq_mode = 1'b0;
  endtask

  task automatic test_reset_mid();
    int a;
    a = cyc;
    push_sess(0, a, a + N + 2, 1'b0);
    req_i = 4'b0001;
    run_to(a + 4);
    rst_n = 1'b0;
    sb.delete();
    model_sig = '0;
    #2;
    n_chk++;
    if ({gnt_o, busy_o, resp_valid_o, misr_en_o, misr_done_in_o} !== '0 || misr_data_o !== '0 ||
        resp_sig_o !== '0)
      $display("FAIL midreset gnt=%b busy=%b vld=%b en=%b din=%b data=%h sig=%h, expected all 0",
               gnt_o, busy_o, resp_valid_o, misr_en_o, misr_done_in_o, misr_data_o, resp_sig_o);
    else n_pass++;
    req_i = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    a = cyc;
    push_sess(0, a, a + N + 2, 1'b0);
    req_i = 4'b0001;
    run_to(a + N + 2);
    req_i = '0;
    run_to(a + P);
  endtask

`ifdef MISR_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int a, rc;
    a = cyc;
    rc = a + N + 1 + TO_CYC;
    block_done = 1'b1;
    golden_i[N +: N] = next_sig(1, a, model_sig);
    push_sess(1, a, rc, 1'b1);
    req_i = 4'b0010;
    run_to(rc - 1); #2;
    n_chk++;
    if (resp_valid_o !== 1'b0 || busy_o !== 1'b1)
      $display("FAIL to_wait vld=%b busy=%b, expected 0 1", resp_valid_o, busy_o);
    else n_pass++;
    run_to(rc); #2;
    n_chk++;
    if (to_err_o !== 1'b1 || resp_pass_o !== 1'b0)
      $display("FAIL to_err err=%b pass=%b, expected 1 0", to_err_o, resp_pass_o);
    else n_pass++;
    req_i = '0;
    run_to(rc + 1); #2;
    n_chk++;
    if ({misr_en_o, misr_done_in_o, to_err_o} !== 3'b110)
      $display("FAIL to_rearm en=%b din=%b err=%b, expected 1 1 0", misr_en_o, misr_done_in_o, to_err_o);
    else n_pass++;
    block_done = 1'b0;
    run_to(rc + 3);
  endtask
`endif

  initial begin
    rst_n = 1'b0; req_i = '0; golden_i = '0; data_i = '0; poly_i = POLY;
    model_sig = '0; seq_mode = 1'b0; seq_base = 0; block_done = 1'b0;
    tick(); tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_rr_all();
    test_wrap();
    test_single(1'b0);
    test_single(1'b1);
    test_reset_mid();
`ifdef MISR_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    tick(); tick(); #2;
    n_chk++;
    if (sb.size() != 0) $display("FAIL pending_results %0d left, expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
